// File: rtl/aes_key_expand_pkg.sv
// Shared AES constants and helpers: key-size derived word counts, Rcon, S-box and
// the key-schedule FSM state encoding.
package aes_key_expand_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    function automatic int key_nk(input int keySize);
        return keySize / 32;
    endfunction

    function automatic int key_nr(input int keySize);
        return key_nk(keySize) + 6;
    endfunction

    function automatic int key_nw(input int keySize);
        return 4 * (key_nr(keySize) + 1);
    endfunction

    // Forward S-box, byte 0x00 in the top byte down to byte 0xff in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        msb = ~{b, 3'b000};
        return SBOX_TABLE[msb -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Request / round-key read bus between the key schedule and its cipher consumer.
interface aes_key_expand_if #(parameter int KEY_SIZE = 256);

    logic                start;
    logic [KEY_SIZE-1:0] key;
    logic [3:0]          rk_idx;
    logic [127:0]        rk;
    logic                busy;
    logic                ready;

    modport master (output start, key, rk_idx, input rk, busy, ready);
    modport slave  (input start, key, rk_idx, output rk, busy, ready);

endinterface

// File: rtl/aes_key_expand_sbox.sv
// Single combinational 8-bit forward AES S-box lookup.
module aes_key_expand_sbox
    import aes_key_expand_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = sbox(in_i);

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one 32-bit schedule word per cycle into a word store,
// then serves round keys by index through a registered read port.
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int KEY_SIZE = 256
)
(
    input  logic           clk,
    input  logic           rst,
    aes_key_expand_if.slave bus
);

    localparam int NK = key_nk(KEY_SIZE);
    localparam int NR = key_nr(KEY_SIZE);
    localparam int NW = key_nw(KEY_SIZE);

    localparam logic [5:0] NK_W    = 6'(NK);
    localparam logic [5:0] LAST_W  = 6'(NW - 1);
    localparam logic [2:0] PH_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_W    = 4'(NR);

    state_e         state_q;
    logic [5:0]     i_q;
    logic [2:0]     phase_q;
    logic [3:0]     round_q;
    logic           busy_q;
    logic           ready_q;
    logic [127:0]   rk_q;
    logic [127:0]   rk_d;
    logic [31:0]    w_q [NW];

    logic [31:0]    prevWord;
    logic [31:0]    sbIn;
    logic [31:0]    sbOut;
    logic [31:0]    temp;
    logic [31:0]    newWord;
    logic [5:0]     base;

    // Next schedule word; phase_q tracks i mod Nk and round_q tracks i / Nk.
    always_comb begin
        prevWord = w_q[i_q - 6'd1];
        sbIn     = (phase_q == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
        temp     = prevWord;
        if (phase_q == 3'd0) begin
            temp = sbOut ^ {rcon(round_q), 24'h0};
        end else if (NK == 8 && phase_q == 3'd4) begin
            temp = sbOut;
        end
        newWord = w_q[i_q - NK_W] ^ temp;
    end

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_key_expand_sbox u_sbox (
            .in_i  (sbIn[8*b +: 8]),
            .out_o (sbOut[8*b +: 8])
        );
    end

    always_comb begin
        base = {bus.rk_idx, 2'b00};
        rk_d = '0;
        if (bus.rk_idx <= NR_W) begin
            rk_d = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            phase_q <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            rk_q    <= '0;
        end else begin
            rk_q <= rk_d;
            if (bus.start) begin
                state_q <= EXPAND;
                i_q     <= NK_W;
                phase_q <= '0;
                round_q <= 4'd1;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
            end else if (state_q == EXPAND) begin
                i_q <= i_q + 6'd1;
                if (phase_q == PH_LAST) begin
                    phase_q <= '0;
                    round_q <= round_q + 4'd1;
                end else begin
                    phase_q <= phase_q + 3'd1;
                end
                if (i_q == LAST_W) begin
                    state_q <= READY;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    // The store holds no reset value; contents only matter once ready is set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.start) begin
                for (int k = 0; k < NK; k++) begin
                    w_q[k] <= bus.key[KEY_SIZE - 1 - 32*k -: 32];
                end
            end else if (state_q == EXPAND) begin
                w_q[i_q] <= newWord;
            end
        end
    end

    assign bus.rk    = rk_q;
    assign bus.busy  = busy_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand at all three key sizes against a textbook key-schedule
// model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_key_expand_if #(.KEY_SIZE(128)) i128 ();
    aes_key_expand_if #(.KEY_SIZE(192)) i192 ();
    aes_key_expand_if #(.KEY_SIZE(256)) i256 ();

    aes_key_expand #(.KEY_SIZE(128)) dut128 (.clk(clk), .rst(rst), .bus(i128.slave));
    aes_key_expand #(.KEY_SIZE(192)) dut192 (.clk(clk), .rst(rst), .bus(i192.slave));
    aes_key_expand #(.KEY_SIZE(256)) dut256 (.clk(clk), .rst(rst), .bus(i256.slave));

    typedef struct {
        int           ks;
        logic [255:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    int          testsRun  = 0;
    int          failCount = 0;
    logic [7:0]  sboxRef [256];
    logic [31:0] model   [60];
    vec_t        vecs    [6];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic initSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
    endfunction

    function automatic logic [7:0] rconRef(input int n);
        logic [7:0] rc = 8'h01;
        for (int k = 1; k < n; k++) rc = xtime(rc);
        return rc;
    endfunction

    // Textbook FIPS-197 key expansion over plain arrays and arithmetic.
    task automatic buildModel(input int ks, input logic [255:0] key);
        int nk = ks / 32;
        int nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) model[i] = key[ks - 1 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            logic [31:0] t = model[i - 1];
            if (i % nk == 0) t = subWord({t[23:0], t[31:24]}) ^ {rconRef(i / nk), 24'h0};
            else if (nk == 8 && i % nk == 4) t = subWord(t);
            model[i] = model[i - nk] ^ t;
        end
    endtask

    function automatic logic [127:0] modelRk(input int ks, input int r);
        if (r > ks / 32 + 6) return 128'h0;
        return {model[4*r], model[4*r + 1], model[4*r + 2], model[4*r + 3]};
    endfunction

    task automatic drive(input int ks, input logic s, input logic [255:0] k);
        case (ks)
            128:     begin i128.start = s; i128.key = k[127:0]; end
            192:     begin i192.start = s; i192.key = k[191:0]; end
            default: begin i256.start = s; i256.key = k;        end
        endcase
    endtask

    task automatic setIdx(input int ks, input logic [3:0] idx);
        case (ks)
            128:     i128.rk_idx = idx;
            192:     i192.rk_idx = idx;
            default: i256.rk_idx = idx;
        endcase
    endtask

    function automatic logic [127:0] getRk(input int ks);
        return (ks == 128) ? i128.rk : (ks == 192) ? i192.rk : i256.rk;
    endfunction

    function automatic logic getReady(input int ks);
        return (ks == 128) ? i128.ready : (ks == 192) ? i192.ready : i256.ready;
    endfunction

    function automatic logic getBusy(input int ks);
        return (ks == 128) ? i128.busy : (ks == 192) ? i192.busy : i256.busy;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Single-cycle start pulse; returns at the falling edge right after the start edge.
    task automatic applyStimulus(input int ks, input logic [255:0] key);
        @(negedge clk);
        drive(ks, 1'b1, key);
        @(negedge clk);
        drive(ks, 1'b0, '0);
    endtask

    task automatic waitReady(input int ks, input string name);
        int nk = ks / 32;
        int lat = 0;
        checkOutput({name, " ready low after start"}, 128'(getReady(ks)), 128'h0);
        checkOutput({name, " busy after start"}, 128'(getBusy(ks)), 128'h1);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (getReady(ks)) begin
                lat = n;
                break;
            end
        end
        checkOutput({name, " latency"}, 128'(lat), 128'(3*nk + 28));
        checkOutput({name, " busy at ready"}, 128'(getBusy(ks)), 128'h0);
    endtask

    // Applies a new index every cycle and checks every round key plus out-of-range ones.
    task automatic readAll(input int ks, input string name);
        @(negedge clk);
        setIdx(ks, 4'd0);
        for (int r = 1; r <= 16; r++) begin
            @(negedge clk);
            checkOutput($sformatf("%s rk%0d", name, r - 1), getRk(ks), modelRk(ks, r - 1));
            if (r < 16) setIdx(ks, 4'(r));
        end
    endtask

    initial begin
        logic [255:0] keyA;
        logic [255:0] keyB;
        int           seen;

        vecs[0] = '{128, 256'h000102030405060708090a0b0c0d0e0f, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[1] = '{128, 256'h000102030405060708090a0b0c0d0e0f, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[2] = '{128, 256'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{128, 256'h2b7e151628aed2a6abf7158809cf4f3c, 4'd11, 128'h0};
        vecs[4] = '{192, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 4'd12,
                    128'ha4970a331a78dc09c418c271e3a41d5d};
        vecs[5] = '{256, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 4'd14,
                    128'h24fc79ccbf0979e9371ac23c6d68de36};

        initSbox();
        rst = 1'b1;
        drive(128, 1'b0, '0); drive(192, 1'b0, '0); drive(256, 1'b0, '0);
        setIdx(128, 4'd0); setIdx(192, 4'd0); setIdx(256, 4'd0);
        repeat (3) @(negedge clk);
        foreach (vecs[v]) begin
            if (v == 0 || v == 4 || v == 5) begin
                checkOutput($sformatf("reset busy %0d", vecs[v].ks), 128'(getBusy(vecs[v].ks)), 128'h0);
                checkOutput($sformatf("reset ready %0d", vecs[v].ks), 128'(getReady(vecs[v].ks)), 128'h0);
                checkOutput($sformatf("reset rk %0d", vecs[v].ks), getRk(vecs[v].ks), 128'h0);
            end
        end
        rst = 1'b0;

        foreach (vecs[v]) begin
            applyStimulus(vecs[v].ks, vecs[v].key);
            waitReady(vecs[v].ks, $sformatf("vec%0d", v));
            setIdx(vecs[v].ks, vecs[v].idx);
            @(negedge clk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d rk", v), getRk(vecs[v].ks), vecs[v].exp);
        end

        for (int s = 0; s < 3; s++) begin
            int ks = 128 + 64*s;
            for (int n = 0; n < 2; n++) begin
                keyA = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                applyStimulus(ks, keyA);
                waitReady(ks, $sformatf("rand%0d_%0d", ks, n));
                buildModel(ks, keyA);
                readAll(ks, $sformatf("rand%0d_%0d", ks, n));
            end
        end

        keyA = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        keyB = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        applyStimulus(256, keyA);
        repeat (9) @(negedge clk);
        applyStimulus(256, keyB);
        waitReady(256, "restart");
        buildModel(256, keyB);
        readAll(256, "restart");

        keyA = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        applyStimulus(128, keyA);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst busy", 128'(getBusy(128)), 128'h0);
        checkOutput("midrst ready", 128'(getReady(128)), 128'h0);
        checkOutput("midrst rk", getRk(128), 128'h0);
        keyB = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        applyStimulus(128, keyB);
        waitReady(128, "after rst");
        buildModel(128, keyB);
        readAll(128, "after rst");

        @(negedge clk);
        rst = 1'b1;
        drive(128, 1'b1, keyA);
        @(negedge clk);
        rst = 1'b0;
        drive(128, 1'b0, '0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (getBusy(128) || getReady(128)) seen++;
        end
        checkOutput("rst+start idle", 128'(seen), 128'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
